// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction at a time, runs data-memory accesses, and drives the register-file write port.
// Optional build macro WB_TIMEOUT_EN aborts memory accesses that are not acknowledged within TIMEOUT cycles.
module wb_stage #(
   parameter int DW      = 8,
   parameter int RW      = 3,
   parameter int AW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    opcode,
   input  logic [RW-1:0] dest,
   input  logic [AW-1:0] dmaddr,
   input  logic [DW-1:0] result,
   output logic          dm_req,
   output logic          dm_we,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   input  logic          dm_ack,
   input  logic [DW-1:0] dm_rdata,
   output logic          write,
   output logic [RW-1:0] wR,
   output logic [DW-1:0] dataIn,
   output logic          fwd_valid,
   output logic [RW-1:0] fwd_dest,
   output logic [DW-1:0] fwd_data,
   output logic [7:0]    retired,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state_reg;
   logic          dm_req_reg;
   logic          dm_we_reg;
   logic [AW-1:0] dm_addr_reg;
   logic [DW-1:0] dm_wdata_reg;
   logic          write_reg;
   logic [RW-1:0] wr_reg;
   logic [DW-1:0] data_reg;
   logic [RW-1:0] dest_reg;
   logic [7:0]    retired_reg;
   logic          err_reg;
   logic [TW-1:0] tmo_cnt_reg;

   logic accept;
   logic is_alu;
   logic is_mem;

   assign in_ready = (state_reg == IDLE) && !reset;
   assign accept   = in_valid && in_ready;
   assign is_alu   = (opcode >= 4'h1) && (opcode <= 4'h7);
   assign is_mem   = (opcode == 4'h8) || (opcode == 4'h9);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         dm_req_reg   <= 1'b0;
         dm_we_reg    <= 1'b0;
         dm_addr_reg  <= '0;
         dm_wdata_reg <= '0;
         write_reg    <= 1'b0;
         wr_reg       <= '0;
         data_reg     <= '0;
         dest_reg     <= '0;
         retired_reg  <= '0;
         err_reg      <= 1'b0;
         tmo_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (is_alu) begin
                     state_reg <= WB;
                     write_reg <= 1'b1;
                     wr_reg    <= dest;
                     data_reg  <= result;
                  end else if (is_mem) begin
                     state_reg    <= MEM;
                     dm_req_reg   <= 1'b1;
                     dm_we_reg    <= (opcode == 4'h9);
                     dm_addr_reg  <= dmaddr;
                     dm_wdata_reg <= result;
                     dest_reg     <= dest;
                     tmo_cnt_reg  <= '0;
                  end else begin
                     retired_reg <= retired_reg + 8'd1;
                  end
               end
            end
            MEM: begin
               // An ack on the expiry edge wins over the abort.
               if (dm_ack) begin
                  dm_req_reg <= 1'b0;
                  if (dm_we_reg) begin
                     state_reg   <= IDLE;
                     retired_reg <= retired_reg + 8'd1;
                  end else begin
                     state_reg <= WB;
                     write_reg <= 1'b1;
                     wr_reg    <= dest_reg;
                     data_reg  <= dm_rdata;
                  end
               end
`ifdef WB_TIMEOUT_EN
               else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
                  dm_req_reg <= 1'b0;
                  err_reg    <= 1'b1;
                  state_reg  <= IDLE;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
`endif
            end
            WB: begin
               write_reg   <= 1'b0;
               retired_reg <= retired_reg + 8'd1;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign dm_req    = dm_req_reg;
   assign dm_we     = dm_we_reg;
   assign dm_addr   = dm_addr_reg;
   assign dm_wdata  = dm_wdata_reg;
   assign write     = write_reg;
   assign wR        = wr_reg;
   assign dataIn    = data_reg;
   assign fwd_valid = write_reg;
   assign fwd_dest  = wr_reg;
   assign fwd_data  = data_reg;
   assign retired   = retired_reg;
`ifdef WB_TIMEOUT_EN
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU, load, store, NOPs, reset mid-access, timeout/indefinite wait, retired wrap.
module tb_wb_stage;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [2:0] dest;
   logic [3:0] dmaddr;
   logic [7:0] result;
   logic       dm_req;
   logic       dm_we;
   logic [3:0] dm_addr;
   logic [7:0] dm_wdata;
   logic       dm_ack;
   logic [7:0] dm_rdata;
   logic       write;
   logic [2:0] wR;
   logic [7:0] dataIn;
   logic       fwd_valid;
   logic [2:0] fwd_dest;
   logic [7:0] fwd_data;
   logic [7:0] retired;
   logic       err;

   int total = 0;
   int bad   = 0;

   wb_stage #(.DW(8), .RW(3), .AW(4), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .dest(dest), .dmaddr(dmaddr), .result(result),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .write(write), .wR(wR), .dataIn(dataIn),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .retired(retired), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [3:0] a, input logic [7:0] r);
      in_valid = 1'b1; opcode = op; dest = d; dmaddr = a; result = r;
      step();
      in_valid = 1'b0; opcode = 4'hF; dest = 3'd7; dmaddr = 4'hF; result = 8'hEE;
   endtask

   initial begin
      int n;
      reset = 1'b1; in_valid = 1'b0; opcode = 4'h0; dest = 3'd0; dmaddr = 4'h0;
      result = 8'h00; dm_ack = 1'b0; dm_rdata = 8'h00;
      step(); step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
      chk("rst_write", {31'd0, write}, 32'd0);
      chk("rst_retired", {24'd0, retired}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      reset = 1'b0; #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // ALU: opcode 1, r3 <= 0x5A
      issue(4'h1, 3'd3, 4'h0, 8'h5A);
      chk("alu_in_ready", {31'd0, in_ready}, 32'd0);
      chk("alu_write", {31'd0, write}, 32'd1);
      chk("alu_wR", {29'd0, wR}, 32'd3);
      chk("alu_dataIn", {24'd0, dataIn}, 32'h5A);
      chk("alu_fwd", {19'd0, fwd_valid, fwd_dest, fwd_data}, {19'd0, 1'b1, 3'd3, 8'h5A});
      step();
      chk("alu_write_off", {31'd0, write}, 32'd0);
      chk("alu_ready_back", {31'd0, in_ready}, 32'd1);
      chk("alu_retired", {24'd0, retired}, 32'd1);

      // LOAD: r5 <= mem[0xA], ack in the third request cycle
      issue(4'h8, 3'd5, 4'hA, 8'h00);
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("ld_req_c%0d", c), {26'd0, dm_req, dm_we, dm_addr}, {26'd0, 1'b1, 1'b0, 4'hA});
         chk($sformatf("ld_nowrite_c%0d", c), {31'd0, write}, 32'd0);
         if (c == 3) begin dm_ack = 1'b1; dm_rdata = 8'h3C; end
         step();
      end
      dm_ack = 1'b0; dm_rdata = 8'h00;
      chk("ld_req_drop", {31'd0, dm_req}, 32'd0);
      chk("ld_write", {20'd0, write, wR, dataIn}, {20'd0, 1'b1, 3'd5, 8'h3C});
      step();
      chk("ld_write_off", {31'd0, write}, 32'd0);
      chk("ld_retired", {24'd0, retired}, 32'd2);

      // STORE: mem[0x2] <= 0x77, immediate ack
      issue(4'h9, 3'd1, 4'h2, 8'h77);
      chk("st_req", {18'd0, dm_req, dm_we, dm_addr, dm_wdata}, {18'd0, 1'b1, 1'b1, 4'h2, 8'h77});
      chk("st_nowrite", {31'd0, write}, 32'd0);
      dm_ack = 1'b1;
      step();
      dm_ack = 1'b0;
      chk("st_req_drop", {31'd0, dm_req}, 32'd0);
      chk("st_nowrite2", {31'd0, write}, 32'd0);
      chk("st_retired", {24'd0, retired}, 32'd3);
      chk("st_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back NOPs: opcode 0 then 0xC
      in_valid = 1'b1; opcode = 4'h0; step();
      chk("nop0_retired", {24'd0, retired}, 32'd4);
      chk("nop0_quiet", {29'd0, in_ready, dm_req, write}, {29'd0, 3'b100});
      opcode = 4'hC; step();
      in_valid = 1'b0;
      chk("nopC_retired", {24'd0, retired}, 32'd5);
      chk("nopC_quiet", {29'd0, in_ready, dm_req, write}, {29'd0, 3'b100});

      // Write to r0 passes through; inputs while busy are ignored
      issue(4'h7, 3'd0, 4'h0, 8'hFF);
      in_valid = 1'b1; opcode = 4'h1; dest = 3'd6; result = 8'h11;
      chk("r0_write", {20'd0, write, wR, dataIn}, {20'd0, 1'b1, 3'd0, 8'hFF});
      step();
      in_valid = 1'b0;
      chk("busy_ignored", {20'd0, write, wR, dataIn}, {20'd0, 1'b0, 3'd0, 8'hFF});
      chk("r0_retired", {24'd0, retired}, 32'd6);

      // Reset during the second request cycle of a LOAD
      issue(4'h8, 3'd2, 4'h4, 8'h00);
      step();
      chk("rstmem_req_c2", {31'd0, dm_req}, 32'd1);
      reset = 1'b1; step(); reset = 1'b0; #1;
      chk("rstmem_req", {31'd0, dm_req}, 32'd0);
      chk("rstmem_write", {31'd0, write}, 32'd0);
      chk("rstmem_retired", {24'd0, retired}, 32'd0);
      chk("rstmem_idle", {31'd0, in_ready}, 32'd1);
      dm_ack = 1'b1; step(); dm_ack = 1'b0;
      chk("rstmem_stray_ack", {30'd0, write, dm_req}, 32'd0);

`ifdef WB_TIMEOUT_EN
      // Never-acked LOAD aborts after 4 request cycles
      issue(4'h8, 3'd4, 4'h1, 8'h00);
      n = 0;
      while (dm_req && n < 20) begin
         chk($sformatf("to_nowrite_c%0d", n), {31'd0, write}, 32'd0);
         n++;
         step();
      end
      chk("to_req_cycles", n, 32'd4);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_write", {31'd0, write}, 32'd0);
      chk("to_retired", {24'd0, retired}, 32'd0);
      chk("to_idle", {31'd0, in_ready}, 32'd1);
`else
      // Without timeout support the request waits indefinitely
      issue(4'h8, 3'd4, 4'h1, 8'h00);
      n = 0;
      repeat (20) begin
         if (dm_req) n++;
         step();
      end
      chk("wait_req_cycles", n, 32'd20);
      chk("wait_err", {31'd0, err}, 32'd0);
      dm_ack = 1'b1; dm_rdata = 8'hA5; step(); dm_ack = 1'b0;
      chk("wait_write", {20'd0, write, wR, dataIn}, {20'd0, 1'b1, 3'd4, 8'hA5});
`endif

      // retired wraps after 256 NOPs from reset
      reset = 1'b1; step(); reset = 1'b0;
      in_valid = 1'b1; opcode = 4'h0;
      repeat (255) step();
      chk("wrap_255", {24'd0, retired}, 32'd255);
      step();
      in_valid = 1'b0;
      chk("wrap_0", {24'd0, retired}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
